// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, operand constants and validity helper
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam bcd_digit_t INC_OP  = 4'b0001;
  localparam bcd_digit_t DEC_OP  = 4'b1111;

  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit register stepped through fadder_4bit
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RST_DIGIT = BCD_MIN
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       step_i,
  input  logic       up_i,
  output bcd_digit_t digit_o,
  output logic       bound_o,
  output logic       step_o
);

  bcd_digit_t r_digit;
  bcd_digit_t w_sum;
  bcd_digit_t w_next;
  logic       w_co;

  fadder_4bit u_add (
    .a_i (r_digit),
    .b_i (up_i ? INC_OP : DEC_OP),
    .c_i (1'b0),
    .s_o (w_sum),
    .c_o (w_co)
  );

  // Adding 4'b1111 carries out for every digit except 0, so a missing carry marks the borrow.
  assign bound_o = up_i ? (r_digit == BCD_MAX) : ~w_co;
  assign step_o  = step_i & bound_o;
  assign digit_o = r_digit;

  always_comb begin
    w_next = r_digit;
    if (clr_i) begin
      w_next = RST_DIGIT;
    end else if (load_i) begin
      w_next = load_val_i;
    end else if (step_i) begin
      w_next = bound_o ? (up_i ? BCD_MIN : BCD_MAX) : w_sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_digit <= RST_DIGIT;
    end else begin
      r_digit <= w_next;
    end
  end

endmodule

// File: rtl/fadder_4bit.sv
// rtl/fadder_4bit.sv - 4-bit ripple full adder with carry in/out
module fadder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};

endmodule

// File: rtl/bcd_counter_2digit.sv
// rtl/bcd_counter_2digit.sv - two-digit BCD up/down counter with load check and wrap/saturate
module bcd_counter_2digit
  import bcd_pkg::*;
#(
  parameter bit         WRAP_EN = 1'b1,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  input  logic       up_i,
  output logic [7:0] cnt_o,
  output logic       tc_o,
  output logic       ovf_o,
  output logic       err_o
);

  bcd_digit_t w_ones;
  bcd_digit_t w_tens;
  logic       w_ones_bound;
  logic       w_tens_bound;
  logic       w_ones_step;
  logic       w_tens_step;
  logic       w_load_valid;
  logic       w_load_ok;
  logic       w_count;
  logic       w_hit;
  logic       r_ovf;
  logic       r_err;

  assign w_load_valid = is_bcd(load_val_i[7:4]) & is_bcd(load_val_i[3:0]);
  assign w_load_ok    = load_i & ~clr_i & w_load_valid;
  assign w_count      = en_i & ~clr_i & ~load_i;
  assign w_hit        = w_ones_bound & w_tens_bound;

  // In saturate mode the step at the bound is swallowed before it reaches either digit.
  bcd_digit #(.RST_DIGIT(RST_VAL[3:0])) u_ones (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .load_i     (w_load_ok),
    .load_val_i (load_val_i[3:0]),
    .step_i     (w_count & ~(w_hit & ~WRAP_EN)),
    .up_i       (up_i),
    .digit_o    (w_ones),
    .bound_o    (w_ones_bound),
    .step_o     (w_ones_step)
  );

  bcd_digit #(.RST_DIGIT(RST_VAL[7:4])) u_tens (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .load_i     (w_load_ok),
    .load_val_i (load_val_i[7:4]),
    .step_i     (w_ones_step),
    .up_i       (up_i),
    .digit_o    (w_tens),
    .bound_o    (w_tens_bound),
    .step_o     (w_tens_step)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= WRAP_EN ? w_tens_step : (w_count & w_hit);
      r_err <= load_i & ~clr_i & ~w_load_valid;
    end
  end

  assign cnt_o = {w_tens, w_ones};
  assign tc_o  = up_i ? (cnt_o == 8'h99) : (cnt_o == 8'h00);
  assign ovf_o = r_ovf;
  assign err_o = r_err;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// tb/tb_bcd_counter_2digit.sv - bench for bcd_counter_2digit, wrap and saturate instances
module tb_bcd_counter_2digit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en, up;
  logic [7:0] load_val;
  logic [7:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s, err_w, err_s;

  int n_cmp  = 0;
  int n_fail = 0;

  int   m_val [2];
  logic m_ovf [2];
  logic m_err [2];

  always #5 clk = ~clk;

  bcd_counter_2digit #(.WRAP_EN(1'b1), .RST_VAL(8'h00)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_i(up), .cnt_o(cnt_w), .tc_o(tc_w), .ovf_o(ovf_w), .err_o(err_w)
  );

  bcd_counter_2digit #(.WRAP_EN(1'b0), .RST_VAL(8'h00)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_i(up), .cnt_o(cnt_s), .tc_o(tc_s), .ovf_o(ovf_s), .err_o(err_s)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Reference: the count as a plain decimal integer 0..99; index 0 wraps, index 1 saturates.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_val[i] <= 0;
        m_ovf[i] <= 1'b0;
        m_err[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int   v;
        logic o, e;
        v = m_val[i];
        o = 1'b0;
        e = 1'b0;
        if (clr) begin
          v = 0;
        end else if (load) begin
          if (load_val[7:4] <= 4'd9 && load_val[3:0] <= 4'd9)
            v = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
          else
            e = 1'b1;
        end else if (en) begin
          if (up) begin
            if (v == 99) begin o = 1'b1; v = (i == 0) ? 0 : 99; end
            else v = v + 1;
          end else begin
            if (v == 0) begin o = 1'b1; v = (i == 0) ? 99 : 0; end
            else v = v - 1;
          end
        end
        m_val[i] <= v;
        m_ovf[i] <= o;
        m_err[i] <= e;
      end
    end
  end

  always @(negedge clk) begin
    check("model_cnt_w", cnt_w, to_bcd(m_val[0]));
    check("model_cnt_s", cnt_s, to_bcd(m_val[1]));
    check("model_ovf_w", {7'd0, ovf_w}, {7'd0, m_ovf[0]});
    check("model_ovf_s", {7'd0, ovf_s}, {7'd0, m_ovf[1]});
    check("model_err_w", {7'd0, err_w}, {7'd0, m_err[0]});
    check("model_err_s", {7'd0, err_s}, {7'd0, m_err[1]});
    check("model_tc_w", {7'd0, tc_w}, {7'd0, (up ? m_val[0] == 99 : m_val[0] == 0)});
    check("model_tc_s", {7'd0, tc_s}, {7'd0, (up ? m_val[1] == 99 : m_val[1] == 0)});
  end

  task automatic drive(input bit c, input bit l, input logic [7:0] lv, input bit e, input bit u);
    clr = c; load = l; load_val = lv; en = e; up = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_up  [4];
    logic [7:0] exp_ovf [4];
    logic [7:0] exp_tc  [4];
    logic [7:0] exp_tog [4];
    logic [7:0] lv;
    bit         u;

    rst_n = 1'b0; clr = 0; load = 0; load_val = 8'h00; en = 0; up = 1;
    #3;
    check("rst_cnt_w", cnt_w, 8'h00);
    check("rst_cnt_s", cnt_s, 8'h00);
    check("rst_ovf_err", {6'd0, ovf_w, err_w}, 8'h00);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    exp_up  = '{8'h98, 8'h99, 8'h00, 8'h01};
    exp_ovf = '{8'h00, 8'h00, 8'h01, 8'h00};
    exp_tc  = '{8'h00, 8'h01, 8'h00, 8'h00};
    drive(0, 1, 8'h97, 0, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1, 1);
      check("up_wrap_cnt", cnt_w, exp_up[k]);
      check("up_wrap_ovf", {7'd0, ovf_w}, exp_ovf[k]);
      check("up_wrap_tc", {7'd0, tc_w}, exp_tc[k]);
    end

    exp_ovf = '{8'h00, 8'h01, 8'h01, 8'h00};
    drive(0, 1, 8'h01, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      check("down_sat_cnt", cnt_s, 8'h00);
      check("down_sat_ovf", {7'd0, ovf_s}, exp_ovf[k]);
      check("down_sat_tc", {7'd0, tc_s}, 8'h01);
    end

    drive(0, 1, 8'h35, 0, 1);
    drive(0, 1, 8'h3A, 0, 1);
    check("bad_load_lo_cnt", cnt_w, 8'h35);
    check("bad_load_lo_err", {7'd0, err_w}, 8'h01);
    drive(0, 1, 8'hA2, 0, 1);
    check("bad_load_hi_cnt", cnt_w, 8'h35);
    check("bad_load_hi_err", {7'd0, err_w}, 8'h01);
    drive(0, 1, 8'h90, 0, 1);
    check("good_load_cnt", cnt_w, 8'h90);
    check("good_load_err", {7'd0, err_w}, 8'h00);

    drive(0, 1, 8'h42, 0, 1);
    drive(1, 1, 8'h55, 1, 1);
    check("prio_clr", cnt_w, 8'h00);
    drive(0, 1, 8'h55, 1, 1);
    check("prio_load", cnt_w, 8'h55);

    drive(0, 1, 8'h09, 0, 1);
    drive(0, 0, 8'h00, 1, 1);
    check("carry_up", cnt_w, 8'h10);
    drive(0, 0, 8'h00, 1, 0);
    check("borrow_down", cnt_w, 8'h09);
    exp_tog = '{8'h51, 8'h50, 8'h51, 8'h50};
    drive(0, 1, 8'h50, 0, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1, (k % 2) == 0);
      check("toggle_dir", cnt_s, exp_tog[k]);
    end

    drive(0, 1, 8'h47, 0, 1);
    check("pre_async_cnt", cnt_w, 8'h47);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt_w, 8'h00);
    check("async_rst_flags", {6'd0, ovf_w, err_w}, 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    u = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15) == 0) u = ~u;
      lv = ($urandom_range(1) == 0) ? 8'($urandom) : {4'($urandom_range(9)), 4'($urandom_range(9))};
      drive($urandom_range(24) == 0, $urandom_range(9) == 0, lv, $urandom_range(3) != 0, u);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
